// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter with a slave-hang watchdog.
// Latency: grant one cycle after cyc rises, then request/response paths are combinational.
// Backpressure: a grant is held for the whole cycle (cyc high); the other master waits.
module wb_arbiter_2m #(
    parameter int TIMEOUT = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [31:0]  m0_wb_adr,
    input  logic [15:0]  m0_wb_sel,
    input  logic         m0_wb_we,
    input  logic [127:0] m0_wb_dat_w,
    input  logic         m0_wb_cyc,
    input  logic         m0_wb_stb,
    output logic [127:0] m0_wb_dat_r,
    output logic         m0_wb_ack,
    output logic         m0_wb_err,
    input  logic [31:0]  m1_wb_adr,
    input  logic [15:0]  m1_wb_sel,
    input  logic         m1_wb_we,
    input  logic [127:0] m1_wb_dat_w,
    input  logic         m1_wb_cyc,
    input  logic         m1_wb_stb,
    output logic [127:0] m1_wb_dat_r,
    output logic         m1_wb_ack,
    output logic         m1_wb_err,
    output logic [31:0]  s_wb_adr,
    output logic [15:0]  s_wb_sel,
    output logic         s_wb_we,
    output logic [127:0] s_wb_dat_w,
    output logic         s_wb_cyc,
    output logic         s_wb_stb,
    input  logic [127:0] s_wb_dat_r,
    input  logic         s_wb_ack,
    input  logic         s_wb_err,
    output logic [1:0]   gnt
);

    typedef enum logic [1:0] {IDLE, G0, G1, ABORT} state_t;

    localparam logic [7:0] WD_LIM = 8'(TIMEOUT - 1);

    state_t     state, nxt_state;
    logic       own, nxt_own;
    logic       last, nxt_last;
    logic [7:0] wd, nxt_wd;
    logic [1:0] nxt_gnt;

    logic in_grant, in_abort, own_cyc, s_resp, arb_vld, arb_who, timeout;
    logic take, who;

    assign in_grant = (state == G0) || (state == G1);
    assign in_abort = (state == ABORT);
    assign own_cyc  = own ? m1_wb_cyc : m0_wb_cyc;
    assign s_resp   = s_wb_ack | s_wb_err;
    // On a tie the master that did not go last wins; otherwise whoever is asking.
    assign arb_vld  = m0_wb_cyc | m1_wb_cyc;
    assign arb_who  = (m0_wb_cyc & m1_wb_cyc) ? ~last : m1_wb_cyc;
    assign timeout  = in_grant & own_cyc & s_wb_stb & ~s_resp & (wd == WD_LIM);

    always_comb begin
        nxt_state = state;
        nxt_own   = own;
        nxt_last  = last;
        nxt_wd    = 8'd0;
        take      = 1'b0;
        who       = 1'b0;
        case (state)
            IDLE: begin
                if (arb_vld) begin
                    take = 1'b1;
                    who  = arb_who;
                end
            end
            G0, G1: begin
                // Owner's cyc is low here, so arb_who can only pick the other master.
                if (!own_cyc) begin
                    if (arb_vld) begin
                        take = 1'b1;
                        who  = arb_who;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else if (timeout) begin
                    nxt_state = ABORT;
                end else if (s_wb_stb && !s_resp) begin
                    nxt_wd = wd + 8'd1;
                end
            end
            ABORT: begin
                if (own_cyc) begin
                    take = 1'b1;
                    who  = own;
                end else if (arb_vld) begin
                    take = 1'b1;
                    who  = arb_who;
                end else begin
                    nxt_state = IDLE;
                end
            end
            default: nxt_state = IDLE;
        endcase
        if (take) begin
            nxt_state = who ? G1 : G0;
            nxt_own   = who;
            nxt_last  = who;
        end
        case (nxt_state)
            G0:      nxt_gnt = 2'b01;
            G1:      nxt_gnt = 2'b10;
            ABORT:   nxt_gnt = nxt_own ? 2'b10 : 2'b01;
            default: nxt_gnt = 2'b00;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            own   <= 1'b0;
            last  <= 1'b1;
            wd    <= 8'd0;
            gnt   <= 2'b00;
        end else begin
            state <= nxt_state;
            own   <= nxt_own;
            last  <= nxt_last;
            wd    <= nxt_wd;
            gnt   <= nxt_gnt;
        end
    end

    assign s_wb_cyc   = in_grant & own_cyc;
    assign s_wb_stb   = in_grant & (own ? m1_wb_stb : m0_wb_stb);
    assign s_wb_adr   = in_grant ? (own ? m1_wb_adr   : m0_wb_adr)   : 32'd0;
    assign s_wb_sel   = in_grant ? (own ? m1_wb_sel   : m0_wb_sel)   : 16'd0;
    assign s_wb_we    = in_grant & (own ? m1_wb_we : m0_wb_we);
    assign s_wb_dat_w = in_grant ? (own ? m1_wb_dat_w : m0_wb_dat_w) : 128'd0;

    assign m0_wb_dat_r = s_wb_dat_r;
    assign m1_wb_dat_r = s_wb_dat_r;
    assign m0_wb_ack   = (state == G0) & s_wb_ack;
    assign m1_wb_ack   = (state == G1) & s_wb_ack;
    assign m0_wb_err   = ((state == G0) & s_wb_err) | (in_abort & ~own);
    assign m1_wb_err   = ((state == G1) & s_wb_err) | (in_abort & own);

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Scoreboard bench for wb_arbiter_2m: per-master expected-response queues drained by a monitor.
module tb_wb_arbiter_2m;

    typedef struct {
        logic         err;
        logic [127:0] dat;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [31:0]  m_adr [2];
    logic [15:0]  m_sel [2];
    logic [127:0] m_dw  [2];
    logic [1:0]   m_we, m_cyc, m_stb;
    wire  [127:0] m0_dr, m1_dr;
    wire          m0_ack, m0_err, m1_ack, m1_err;
    wire  [31:0]  s_adr;
    wire  [15:0]  s_sel;
    wire          s_we, s_cyc, s_stb;
    wire  [127:0] s_dw;
    logic [127:0] s_dr = 128'd0;
    logic         s_ack = 1'b0;
    logic         s_err = 1'b0;
    wire  [1:0]   gnt;

    wb_arbiter_2m #(.TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_wb_adr(m_adr[0]), .m0_wb_sel(m_sel[0]), .m0_wb_we(m_we[0]), .m0_wb_dat_w(m_dw[0]),
        .m0_wb_cyc(m_cyc[0]), .m0_wb_stb(m_stb[0]),
        .m0_wb_dat_r(m0_dr), .m0_wb_ack(m0_ack), .m0_wb_err(m0_err),
        .m1_wb_adr(m_adr[1]), .m1_wb_sel(m_sel[1]), .m1_wb_we(m_we[1]), .m1_wb_dat_w(m_dw[1]),
        .m1_wb_cyc(m_cyc[1]), .m1_wb_stb(m_stb[1]),
        .m1_wb_dat_r(m1_dr), .m1_wb_ack(m1_ack), .m1_wb_err(m1_err),
        .s_wb_adr(s_adr), .s_wb_sel(s_sel), .s_wb_we(s_we), .s_wb_dat_w(s_dw),
        .s_wb_cyc(s_cyc), .s_wb_stb(s_stb),
        .s_wb_dat_r(s_dr), .s_wb_ack(s_ack), .s_wb_err(s_err),
        .gnt(gnt)
    );

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   ack_log[$];
    int   slv_lat = 1;
    bit   silent = 1'b0;
    int   slv_cnt = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, req, $time);
        end
    endtask

    function automatic logic [127:0] rdat(input logic [31:0] a);
        return {4{a ^ 32'hF0801013}};
    endfunction

    // Slave: acks slv_lat cycles after seeing a strobe, unless silent.
    initial forever begin
        @(posedge clk);
        #2;
        s_ack = 1'b0;
        if (s_cyc && s_stb && !silent) begin
            if (slv_cnt >= slv_lat) begin
                s_ack   = 1'b1;
                s_dr    = rdat(s_adr);
                slv_cnt = 0;
            end else begin
                slv_cnt++;
            end
        end else begin
            slv_cnt = 0;
        end
    end

    task automatic pop_resp(input int m);
        exp_t e;
        logic a, er, oth;
        logic [127:0] d;
        a   = (m == 0) ? m0_ack : m1_ack;
        er  = (m == 0) ? m0_err : m1_err;
        d   = (m == 0) ? m0_dr  : m1_dr;
        oth = (m == 0) ? (m1_ack | m1_err) : (m0_ack | m0_err);
        if ((m == 0 && exp_q0.size() == 0) || (m == 1 && exp_q1.size() == 0)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_resp m%0d: ack=%0b err=%0b, none expected at %0t", m, a, er, $time);
        end else begin
            e = (m == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            chk($sformatf("err_flag_m%0d", m), {127'd0, er}, {127'd0, e.err});
            if (!e.err) chk($sformatf("rdata_m%0d", m), d, e.dat);
            chk($sformatf("other_quiet_m%0d", m), {127'd0, oth}, 128'd0);
        end
        ack_log.push_back(m);
    endtask

    always @(negedge clk) begin
        if (m0_ack || m0_err) pop_resp(0);
        if (m1_ack || m1_err) pop_resp(1);
    end

    task automatic m_access(input int m, input int beats, input logic [31:0] adr, input bit exp_err);
        exp_t e;
        int t;
        @(posedge clk);
        #1;
        for (int b = 0; b < beats; b++) begin
            e.err = exp_err;
            e.dat = rdat(adr + 32'(b * 16));
            if (m == 0) exp_q0.push_back(e);
            else        exp_q1.push_back(e);
            m_adr[m] = adr + 32'(b * 16);
            m_cyc[m] = 1'b1;
            m_stb[m] = 1'b1;
            t = 0;
            do begin
                @(negedge clk);
                t++;
            end while (!((m == 0) ? (m0_ack | m0_err) : (m1_ack | m1_err)) && t < 300);
            if (t >= 300) begin
                n_cmp++;
                n_bad++;
                $display("FAIL resp_wait m%0d: no response after %0d cycles, expected one", m, t);
            end
            @(posedge clk);
            #1;
        end
        m_cyc[m] = 1'b0;
        m_stb[m] = 1'b0;
    endtask

    task automatic chk_log(input string nm, input int n, input logic [15:0] pat);
        logic [15:0] act;
        act = 16'd0;
        foreach (ack_log[i]) if (i < 16 && ack_log[i] == 1) act[i] = 1'b1;
        chk({nm, "_len"}, 128'(ack_log.size()), 128'(n));
        chk({nm, "_order"}, {112'd0, act}, {112'd0, pat});
    endtask

    task automatic do_reset(input bit check);
        rst_n = 1'b0;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        repeat (2) @(negedge clk);
        if (check) begin
            chk("rst_s_cyc", {127'd0, s_cyc}, 128'd0);
            chk("rst_s_stb", {127'd0, s_stb}, 128'd0);
            chk("rst_gnt", {126'd0, gnt}, 128'd0);
            chk("rst_acks", {124'd0, m0_ack, m0_err, m1_ack, m1_err}, 128'd0);
            chk("rst_dat_r", m0_dr, s_dr);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        int t, first, nerr;
        exp_t e;
        for (int i = 0; i < 2; i++) begin
            m_adr[i] = 32'd0;
            m_sel[i] = 16'hFFFF;
            m_dw[i]  = 128'd0;
        end
        m_we  = 2'b00;
        m_cyc = 2'b00;
        m_stb = 2'b00;
        s_dr  = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
        do_reset(1'b1);

        // Single master read, slave answers two cycles after its first strobe.
        slv_lat = 2;
        @(posedge clk);
        #1;
        e.err = 1'b0;
        e.dat = {4{32'hF0801003}};
        exp_q0.push_back(e);
        m_adr[0] = 32'h0000_0010;
        m_cyc[0] = 1'b1;
        m_stb[0] = 1'b1;
        @(negedge clk);
        chk("s_cyc_before_grant", {127'd0, s_cyc}, 128'd0);
        @(negedge clk);
        chk("s_cyc_after_grant", {127'd0, s_cyc}, 128'd1);
        chk("gnt_single", {126'd0, gnt}, 128'd1);
        chk("s_adr_single", {96'd0, s_adr}, 128'h10);
        t = 0;
        while (!m0_ack && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("single_ack_seen", {127'd0, m0_ack}, 128'd1);
        @(posedge clk);
        #1;
        m_cyc[0] = 1'b0;
        m_stb[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Tie straight after reset: m0 first, then m1 with no idle gap.
        do_reset(1'b0);
        slv_lat = 1;
        ack_log.delete();
        fork
            m_access(0, 1, 32'h100, 1'b0);
            m_access(1, 1, 32'h200, 1'b0);
            begin
                t = 0;
                do begin @(negedge clk); t++; end while (gnt != 2'b01 && t < 50);
                chk("tie_first_gnt", {126'd0, gnt}, 128'd1);
                t = 0;
                do begin @(negedge clk); t++; end while (gnt == 2'b01 && t < 50);
                chk("handover_gnt", {126'd0, gnt}, 128'd2);
            end
        join
        chk_log("tie", 2, 16'h0002);

        // Fairness over 8 back-to-back single-beat cycles.
        ack_log.delete();
        fork
            begin
                for (int i = 0; i < 4; i++) m_access(0, 1, 32'h1000 + 32'(i * 16), 1'b0);
            end
            begin
                for (int i = 0; i < 4; i++) m_access(1, 1, 32'h2000 + 32'(i * 16), 1'b0);
            end
        join
        chk_log("fair", 8, 16'h00AA);

        // Locked 4-beat m0 cycle while m1 waits.
        ack_log.delete();
        fork
            m_access(0, 4, 32'h400, 1'b0);
            m_access(1, 1, 32'h500, 1'b0);
        join
        chk_log("lock", 5, 16'h0010);

        // Silent slave: one abort 16 cycles after the first slave strobe.
        repeat (2) @(negedge clk);
        silent = 1'b1;
        e.err = 1'b1;
        e.dat = 128'd0;
        exp_q1.push_back(e);
        @(posedge clk);
        #1;
        m_adr[1] = 32'h600;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        first = -1;
        nerr  = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (m1_err) begin
                nerr++;
                if (first < 0) begin
                    first = i;
                    chk("abort_s_cyc", {127'd0, s_cyc}, 128'd0);
                    chk("abort_gnt", {126'd0, gnt}, 128'd2);
                end
            end
        end
        chk("timeout_err_count", 128'(nerr), 128'd1);
        chk("timeout_err_cycle", 128'(first), 128'd17);
        @(posedge clk);
        #1;
        m_cyc[1] = 1'b0;
        m_stb[1] = 1'b0;
        silent = 1'b0;
        ack_log.delete();
        m_access(1, 1, 32'h700, 1'b0);
        chk_log("after_abort", 1, 16'h0001);

        // Asynchronous reset while m1 owns the bus.
        silent = 1'b1;
        @(posedge clk);
        #1;
        m_adr[1] = 32'h800;
        m_cyc[1] = 1'b1;
        m_stb[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_reset_gnt", {126'd0, gnt}, 128'd2);
        chk("pre_reset_stb", {127'd0, s_stb}, 128'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_cyc_stb", {126'd0, s_cyc, s_stb}, 128'd0);
        chk("async_rst_adr", {96'd0, s_adr}, 128'd0);
        chk("async_rst_gnt", {126'd0, gnt}, 128'd0);
        m_cyc = 2'b00;
        m_stb = 2'b00;
        @(negedge clk);
        rst_n  = 1'b1;
        silent = 1'b0;
        ack_log.delete();
        fork
            m_access(0, 1, 32'h900, 1'b0);
            m_access(1, 1, 32'hA00, 1'b0);
        join
        chk_log("post_reset_tie", 2, 16'h0002);

        repeat (3) @(negedge clk);
        chk("exp_q0_drained", 128'(exp_q0.size()), 128'd0);
        chk("exp_q1_drained", 128'(exp_q1.size()), 128'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, expected to finish", $time);
        $fatal(1);
    end

endmodule

// File: doc/wb_arbiter_2m.md
# wb_arbiter_2m

Two-master Wishbone arbiter that shares the Amber core's single 128-bit memory bus between the core (master 0) and a test/program loader (master 1). It sits between the masters and the one memory slave. It grants the bus per Wishbone cycle (`cyc` held high) using round-robin ordering. A watchdog terminates any access the slave never acknowledges, so a hung slave cannot stall verification.

## Interface
- `TIMEOUT`, default 16: number of cycles `s_wb_stb` may stay high without `s_wb_ack`/`s_wb_err` before the arbiter aborts the access. Legal range 2..255.
- `clk` input 1: single clock; all state is updated on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `m0_wb_adr` input 32: master 0 address.
- `m0_wb_sel` input 16: master 0 byte selects.
- `m0_wb_we` input 1: master 0 write enable.
- `m0_wb_dat_w` input 128: master 0 write data.
- `m0_wb_cyc` input 1: master 0 cycle request.
- `m0_wb_stb` input 1: master 0 strobe.
- `m0_wb_dat_r` output 128: read data to master 0.
- `m0_wb_ack` output 1: acknowledge to master 0.
- `m0_wb_err` output 1: error to master 0.
- `m1_wb_*`: identical set of signals for master 1.
- `s_wb_adr` output 32, `s_wb_sel` output 16, `s_wb_we` output 1, `s_wb_dat_w` output 128, `s_wb_cyc` output 1, `s_wb_stb` output 1: slave-side request signals.
- `s_wb_dat_r` input 128, `s_wb_ack` input 1, `s_wb_err` input 1: slave-side response signals.
- `gnt` output 2: one-hot grant (bit0 = m0, bit1 = m1); 2'b00 when idle.

## Operation
- States:
  - IDLE: no grant.
  - G0: m0 owns the bus.
  - G1: m1 owns the bus.
  - ABORT: one-cycle timeout error; the owner is held in `own`.
- Pointer `last` records the last master granted. Reset value is 1, so m0 wins the first tie.
- IDLE:
  - If only one `mX_wb_cyc` is high, go to GX.
  - If both are high, grant the master that is not `last`.
  - Update `last` whenever a grant is issued.
- GX:
  - `s_wb_adr/sel/we/dat_w/stb/cyc` are combinationally muxed from mX.
  - `mX_wb_ack` = `s_wb_ack`; `mX_wb_err` = `s_wb_err`.
  - The non-owner's ack/err are held at 0.
  - `s_wb_dat_r` is broadcast to both `mX_wb_dat_r`.
- Release: when the owner drops `cyc` in GX:
  - If the other master's `cyc` is high, go directly to G(other) and set `last`. There is no dead cycle.
  - Otherwise go to IDLE.
- The grant is never preempted while the owner's `cyc` is high. Burst/locked sequences are atomic.
- Watchdog:
  - 8-bit counter `wd`. It is cleared in IDLE/ABORT and on any cycle where `s_wb_stb` is low or `s_wb_ack | s_wb_err` is high. Otherwise it increments.
  - When `wd == TIMEOUT-1` and still no ack/err, go to ABORT next cycle.
- ABORT:
  - `s_wb_cyc` = `s_wb_stb` = 0.
  - `mOwn_wb_err` = 1 for exactly one cycle; ack = 0.
  - Next state is G(own) if the owner's `cyc` is still high, otherwise apply the IDLE arbitration rules.
- A slave `ack` and `err` asserted in the same cycle are both passed through. The master treats `err` as dominant.

## Timing
- Reset (asynchronous, `rst_n` low):
  - State IDLE, `last` = 1, `wd` = 0, `gnt` = 0.
  - All `s_wb_*` outputs 0.
  - All `mX_wb_ack/err` 0; `mX_wb_dat_r` = `s_wb_dat_r`.
- Reset asserted mid-access drops `s_wb_cyc/stb` immediately, asynchronously. Masters must restart.
- Grant latency: the master raises `cyc` in cycle N and `s_wb_cyc` follows in cycle N+1 (registered state). After that the request path is combinational.
- Response path is combinational: ack/err/dat_r reach the owner in the same cycle the slave drives them.
- Handover: the owner drops `cyc` in cycle N; the other master's signals appear on `s_wb_*` in cycle N+1.
- Timeout: with `stb` first high in cycle N and no response, `wd` reaches TIMEOUT-1 at N+TIMEOUT-1. ABORT occurs in cycle N+TIMEOUT, and the owner sees `err` there.
- `gnt` tracks the state: 01 in G0, 10 in G1, the owner's bit in ABORT, 00 in IDLE.

## Test plan
- Single master: m0 reads address 0x0000_0010 and the slave acks 2 cycles later with data 0xF0801003 repeated -> `s_wb_cyc` rises 1 cycle after `m0_wb_cyc`; `m0_wb_ack` pulses with that data; m1 ack/err stay 0.
- Simultaneous request after reset: both `cyc` rise in the same cycle -> m0 granted first; on m0 release, m1 is granted the next cycle with no IDLE gap; `gnt` goes 01 -> 10.
- Fairness: both masters request continuously with 1-beat cycles -> grants alternate m0, m1, m0, m1 over 8 transactions.
- Lock: m0 holds `cyc` for 4 beats while m1 requests -> m1 is not granted until m0 drops `cyc`; all 4 beats are acked to m0 only.
- Timeout with TIMEOUT=16 and a silent slave: m1 strobes -> `m1_wb_err` pulses exactly once, 16 cycles after `stb`; `s_wb_cyc` is 0 in that cycle; the next m1 access proceeds normally.
- Reset mid-access: `rst_n` low during G1 with `stb` high -> all `s_wb_*` outputs go 0 without waiting for a clock edge; after release, an m0/m1 tie is granted to m0.
